dsp_scheduler: RTL and testbench

Owns the shared 32×32 multiplier and serves the DSP units (sine and its siblings) that use it through the start/finish and mult_a/mult_b/mult_p interface. Arbitrates pending jobs round-robin and runs one unit at a time. While a job runs, the block steers that unit's operands into a two-stage pipelined multiplier and broadcasts the product back. It sits between the voice/mixer control logic, which raises job requests, and the DSP units.

---
 rtl/dsp_pkg.sv | 12 +
 rtl/dsp_scheduler_mult_pipe.sv | 41 ++++
 rtl/dsp_scheduler.sv | 145 ++++++++++++++
 tb/tb_dsp_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared definitions for the DSP multiplier scheduler.
//   MULT_W / PROD_W : operand and product widths of the shared multiplier
//   state_e         : scheduler FSM states
//   client_idx_t    : index of a DSP client (up to 8 clients)
package dsp_pkg;
  localparam int MULT_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

  typedef logic [2:0] client_idx_t;
endpackage

// File: rtl/dsp_scheduler_mult_pipe.sv
// mult_pipe: two-stage registered unsigned multiplier.
//   clk, rst : clock, async active-high reset (clears both stages)
//   a, b     : operands, captured by stage 1
//   p        : full-precision product, registered by stage 2
// Latency from a/b to p is exactly two cycles; a new pair may enter every cycle.
module mult_pipe
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [MULT_W-1:0] a_q, a_d;
  logic [MULT_W-1:0] b_q, b_d;
  logic [PROD_W-1:0] p_q, p_d;

  always_comb begin
    a_d = a;
    b_d = b;
    // Zero-extend before multiplying so the product keeps all 64 bits.
    p_d = PROD_W'(a_q) * PROD_W'(b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/dsp_scheduler.sv
// dsp_scheduler: round-robin owner of the shared 32x32 multiplier.
//   clk, rst             : clock, async active-high reset
//   req[N]               : level job requests, held until ack
//   ack[N]               : one-cycle completion/abort pulse
//   err                  : sticky timeout flag
//   start[N]             : one-cycle start pulse to the granted client
//   finish[N]            : client finish pulses (only the active one counts)
//   cl_mult_a/b[N*32]    : per-client operands, flattened, client i at [i*32 +: 32]
//   mult_p[64]           : product broadcast, 2 cycles after operands are muxed
//   busy                 : FSM not in IDLE
//   active[3]            : granted client index
module dsp_scheduler
  import dsp_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CLIENTS-1:0]        req,
  output logic [N_CLIENTS-1:0]        ack,
  output logic                        err,
  output logic [N_CLIENTS-1:0]        start,
  input  logic [N_CLIENTS-1:0]        finish,
  input  logic [N_CLIENTS*MULT_W-1:0] cl_mult_a,
  input  logic [N_CLIENTS*MULT_W-1:0] cl_mult_b,
  output logic [PROD_W-1:0]           mult_p,
  output logic                        busy,
  output logic [2:0]                  active
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  client_idx_t       active_q, active_d;
  client_idx_t       rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_CLIENTS-1:0] act_oh;
  logic                 fin_act;
  logic [MULT_W-1:0]    op_a, op_b;

  // First set request at or after ptr, wrapping around.
  function automatic client_idx_t rr_pick(input logic [N_CLIENTS-1:0] r,
                                          input client_idx_t ptr);
    client_idx_t pick;
    logic        found;
    int          j;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_CLIENTS) j = j - N_CLIENTS;
      if (!found && ((r & (N_CLIENTS'(1) << j)) != '0)) begin
        pick  = client_idx_t'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign act_oh  = N_CLIENTS'(1) << active_q;
  assign fin_act = |(finish & act_oh);

  // Operands are forced to zero outside RUN so idle-client X never reaches the pipe.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (client_idx_t'(i) == active_q) begin
          op_a = cl_mult_a[i*MULT_W +: MULT_W];
          op_b = cl_mult_b[i*MULT_W +: MULT_W];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          active_d = rr_pick(req, rr_q);
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Finish beats a coincident timeout, leaving err untouched.
        if (fin_act) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rr_d    = (active_q == client_idx_t'(N_CLIENTS - 1)) ? '0 : active_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  mult_pipe u_mult (
    .clk (clk),
    .rst (rst),
    .a   (op_a),
    .b   (op_b),
    .p   (mult_p)
  );

  assign start  = (state_q == START) ? act_oh : '0;
  assign ack    = (state_q == DONE)  ? act_oh : '0;
  assign busy   = (state_q != IDLE);
  assign active = active_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dsp_scheduler.sv
// Randomized bench for dsp_scheduler. A job-level reference model predicts,
// from the request pattern, the grant order and the cycle timestamps of each
// job (start, run window, finish/timeout, ack) plus the product stream.
module tb_dsp_scheduler;
  localparam int N    = 4;
  localparam int TMO  = 15;
  localparam int NCYC = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, ack, start, finish;
  logic            err, busy;
  logic [2:0]      active;
  logic [N*32-1:0] cl_a, cl_b;
  logic [63:0]     mult_p;

  always #5 clk = ~clk;

  dsp_scheduler #(.N_CLIENTS(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .err(err), .start(start),
    .finish(finish), .cl_mult_a(cl_a), .cl_mult_b(cl_b), .mult_p(mult_p),
    .busy(busy), .active(active)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (job timestamps in cycles)
  bit          job_v, timed, ones;
  int          grant, g_c, s_c, rs_c, end_c, ack_c, fin_c, idle_from, rr, err_from;
  logic [63:0] ph [4];
  logic [N-1:0] req_r;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset(input int c);
    job_v = 0; idle_from = c; rr = 0; err_from = 1 << 30;
    for (int i = 0; i < 4; i++) ph[i] = '0;
    req_r = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"},  start,  '0);
    chk({tag, "_ack"},    ack,    '0);
    chk({tag, "_busy"},   busy,   1'b0);
    chk({tag, "_active"}, active, 3'd0);
    chk({tag, "_err"},    err,    1'b0);
    chk({tag, "_multp"},  mult_p, 64'd0);
  endtask

  initial begin
    bit          just_rst, rst_done, in_job, in_run;
    logic [N-1:0] fin;
    logic [31:0] a, b;
    int          len, p, r;
    rst = 1'b1; req = '0; finish = '0; cl_a = '0; cl_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b0;
    model_reset(0);
    just_rst = 1; rst_done = 0;

    for (int c = 0; c < NCYC; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      // Asynchronous reset mid-job: outputs must clear before any clock edge.
      if (!rst_done && c >= 1200 &&
          ((job_v && c > rs_c && c < end_c) || c >= 1500)) begin
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(c);
        just_rst = 1; rst_done = 1;
      end

      // Expected outputs for cycle c
      in_job = job_v && c >= s_c && c <= ack_c;
      in_run = job_v && c >= rs_c && c <= end_c;
      chk("start", start, (job_v && c == s_c)   ? (N'(1) << grant) : '0);
      chk("ack",   ack,   (job_v && c == ack_c) ? (N'(1) << grant) : '0);
      chk("busy",  busy,  in_job);
      chk("err",   err,   c >= err_from);
      chk("multp", mult_p, ph[(c - 2) & 3]);
      if (in_job) chk("active", active, grant);

      // Requests: granted client holds until ack; others come and go.
      if (just_rst) begin
        req_r = 'b0001;
        just_rst = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (job_v && i == grant && c >= g_c && c <= ack_c) req_r[i] = 1'b1;
          else if (job_v && i == grant && c == ack_c + 1) req_r[i] = 1'($urandom_range(0, 1));
          else if (req_r[i]) req_r[i] = ($urandom_range(0, 15) != 0);
          else req_r[i] = ($urandom_range(0, 3) == 0);
        end
      end
      req = req_r;

      // Finish: active client on schedule, plus stray pulses from others.
      fin = '0;
      if (in_run) begin
        if (!timed && c == fin_c) fin[grant] = 1'b1;
        for (int j = 0; j < N; j++)
          if (j != grant && $urandom_range(0, 9) == 0) fin[j] = 1'b1;
      end
      finish = fin;

      // Operands: every client drives garbage; only the runner's pair counts.
      ph[c & 3] = '0;
      for (int i = 0; i < N; i++) begin
        a = $urandom; b = $urandom;
        if (in_run && i == grant) begin
          if (ones) begin a = '1; b = '1; end
          ph[c & 3] = {32'd0, a} * {32'd0, b};
        end
        cl_a[i*32 +: 32] = a;
        cl_b[i*32 +: 32] = b;
      end

      // Grant decision when idle
      if (c >= idle_from) begin
        p = pick(req_r, rr);
        if (p >= 0) begin
          grant = p; g_c = c; s_c = c + 1; rs_c = c + 2;
          r = $urandom_range(0, 9);
          if (r == 0) len = 0;
          else if (r == 1) len = TMO;
          else len = $urandom_range(1, 6);
          if (len == 0) begin
            timed = 1; end_c = rs_c + TMO - 1; fin_c = -1;
          end else begin
            timed = 0; fin_c = rs_c + len - 1; end_c = fin_c;
          end
          ack_c = end_c + 1;
          idle_from = end_c + 2;
          rr = (p + 1) % N;
          if (timed && err_from > ack_c) err_from = ack_c;
          ones = ($urandom_range(0, 3) == 0);
          job_v = 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
